// File: rtl/combo_lock_fsm.sv
// Parametrised combination lock: digit-by-digit entry, re-programmable code,
// failed-attempt counter with timed lockout, and rejection of non-BCD digits.
module combo_lock_fsm #(
  parameter int DIGITS      = 6,
  parameter int DIGIT_W     = 4,
  parameter logic [DIGITS*DIGIT_W-1:0] RESET_CODE = {4'd7, 4'd2, 4'd2, 4'd2, 4'd9, 4'd7},
  parameter int MAX_FAIL    = 3,
  parameter int LOCKOUT_CYC = 1000
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [DIGIT_W-1:0]               digit_in,
  input  logic                             digit_vld,
  input  logic                             retry,
  input  logic                             relock,
  input  logic                             prog,
  output logic [2:0]                       state,
  output logic                             open,
  output logic                             closed,
  output logic                             locked_out,
  output logic [$clog2(DIGITS+1)-1:0]      pos,
  output logic [$clog2(MAX_FAIL+1)-1:0]    fail_cnt,
  output logic                             bad_digit,
  output logic                             code_done
);

  localparam int POS_W  = $clog2(DIGITS+1);
  localparam int FAIL_W = $clog2(MAX_FAIL+1);
  localparam int CNT_W  = (LOCKOUT_CYC > 1) ? $clog2(LOCKOUT_CYC) : 1;
  localparam int CODE_W = DIGITS*DIGIT_W;

  typedef enum logic [2:0] {
    ENTRY   = 3'd0,
    OPEN    = 3'd1,
    CLOSED  = 3'd2,
    PROG    = 3'd3,
    LOCKOUT = 3'd4
  } lockState_e;

  lockState_e          state_q, state_d;
  logic [POS_W-1:0]    pos_q, pos_d;
  logic [FAIL_W-1:0]   fail_q, fail_d;
  logic                mismatch_q, mismatch_d;
  logic [CODE_W-1:0]   code_q, code_d;
  logic [CODE_W-1:0]   shadow_q, shadow_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                bad_q, bad_d;
  logic                done_q, done_d;
  logic                open_q, closed_q, locked_q;

  logic [DIGIT_W-1:0]  codeField;
  logic [CODE_W-1:0]   shadowWr;
  logic                digitOk;
  logic                lastDigit;
  logic                mismatchNext;
  logic [FAIL_W-1:0]   failInc;

  // Field 0 is the most-significant digit of the code word.
  always_comb begin
    codeField = '0;
    shadowWr  = shadow_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (int'(pos_q) == i) begin
        codeField = code_q[(DIGITS-1-i)*DIGIT_W +: DIGIT_W];
        shadowWr[(DIGITS-1-i)*DIGIT_W +: DIGIT_W] = digit_in;
      end
    end
  end

  assign digitOk      = (int'(digit_in) <= 9);
  assign lastDigit    = (pos_q == POS_W'(DIGITS-1));
  assign mismatchNext = mismatch_q | (digit_in != codeField);
  assign failInc      = fail_q + FAIL_W'(1);

  always_comb begin
    state_d    = state_q;
    pos_d      = pos_q;
    fail_d     = fail_q;
    mismatch_d = mismatch_q;
    code_d     = code_q;
    shadow_d   = shadow_q;
    cnt_d      = cnt_q;
    bad_d      = 1'b0;
    done_d     = 1'b0;
    case (state_q)
      ENTRY: begin
        if (digit_vld && !digitOk) begin
          bad_d = 1'b1;
        end else if (digit_vld) begin
          if (lastDigit) begin
            pos_d      = '0;
            mismatch_d = 1'b0;
            if (!mismatchNext) begin
              state_d = OPEN;
              fail_d  = '0;
            end else if (failInc == FAIL_W'(MAX_FAIL)) begin
              state_d = LOCKOUT;
              fail_d  = failInc;
              cnt_d   = CNT_W'(LOCKOUT_CYC-1);
            end else begin
              state_d = CLOSED;
              fail_d  = failInc;
            end
          end else begin
            pos_d      = pos_q + POS_W'(1);
            mismatch_d = mismatchNext;
          end
        end
      end
      OPEN: begin
        if (relock) begin
          state_d = ENTRY;
        end else if (prog) begin
          state_d = PROG;
          pos_d   = '0;
        end
      end
      CLOSED: begin
        if (retry) begin
          state_d = ENTRY;
          pos_d   = '0;
        end
      end
      PROG: begin
        // Abort beats a coincident digit so a half-typed code never lands.
        if (relock) begin
          state_d = ENTRY;
          pos_d   = '0;
        end else if (digit_vld && !digitOk) begin
          bad_d = 1'b1;
        end else if (digit_vld) begin
          shadow_d = shadowWr;
          if (lastDigit) begin
            code_d  = shadowWr;
            done_d  = 1'b1;
            state_d = ENTRY;
            pos_d   = '0;
          end else begin
            pos_d = pos_q + POS_W'(1);
          end
        end
      end
      LOCKOUT: begin
        if (cnt_q == '0) begin
          state_d = ENTRY;
          fail_d  = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = ENTRY;
        pos_d   = '0;
      end
    endcase
  end

  // Status flags are registered from the next state so every output is Moore.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ENTRY;
      pos_q      <= '0;
      fail_q     <= '0;
      mismatch_q <= 1'b0;
      code_q     <= RESET_CODE;
      shadow_q   <= RESET_CODE;
      cnt_q      <= '0;
      bad_q      <= 1'b0;
      done_q     <= 1'b0;
      open_q     <= 1'b0;
      closed_q   <= 1'b0;
      locked_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pos_q      <= pos_d;
      fail_q     <= fail_d;
      mismatch_q <= mismatch_d;
      code_q     <= code_d;
      shadow_q   <= shadow_d;
      cnt_q      <= cnt_d;
      bad_q      <= bad_d;
      done_q     <= done_d;
      open_q     <= (state_d == OPEN);
      closed_q   <= (state_d == CLOSED);
      locked_q   <= (state_d == LOCKOUT);
    end
  end

  assign state      = state_q;
  assign pos        = pos_q;
  assign fail_cnt   = fail_q;
  assign open       = open_q;
  assign closed     = closed_q;
  assign locked_out = locked_q;
  assign bad_digit  = bad_q;
  assign code_done  = done_q;

endmodule

// File: tb/tb_combo_lock_fsm.sv
// Directed bench for combo_lock_fsm with a short lockout so the full
// fail/lockout/recover path fits in a few hundred cycles.
module tb_combo_lock_fsm;

  logic        clk;
  logic        rst_n;
  logic [3:0]  digit_in;
  logic        digit_vld;
  logic        retry;
  logic        relock;
  logic        prog;
  logic [2:0]  state;
  logic        open;
  logic        closed;
  logic        locked_out;
  logic [2:0]  pos;
  logic [1:0]  fail_cnt;
  logic        bad_digit;
  logic        code_done;

  int compareCount = 0;
  int failCount    = 0;

  localparam logic [23:0] CODE_A = {4'd7, 4'd2, 4'd2, 4'd2, 4'd9, 4'd7};
  localparam logic [23:0] CODE_B = {4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6};
  localparam logic [23:0] WRONG1 = {4'd7, 4'd0, 4'd2, 4'd2, 4'd9, 4'd7};
  localparam logic [23:0] WRONG2 = {4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};

  combo_lock_fsm #(
    .DIGITS(6),
    .DIGIT_W(4),
    .RESET_CODE(CODE_A),
    .MAX_FAIL(3),
    .LOCKOUT_CYC(16)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .digit_in(digit_in),
    .digit_vld(digit_vld),
    .retry(retry),
    .relock(relock),
    .prog(prog),
    .state(state),
    .open(open),
    .closed(closed),
    .locked_out(locked_out),
    .pos(pos),
    .fail_cnt(fail_cnt),
    .bad_digit(bad_digit),
    .code_done(code_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    compareCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  // One strobe per call; returns 1 time unit after the sampling edge.
  task automatic applyStimulus(input logic [3:0] d);
    digit_in  = d;
    digit_vld = 1'b1;
    @(posedge clk);
    #1;
    digit_vld = 1'b0;
  endtask

  task automatic enterCode(input logic [23:0] c);
    for (int i = 0; i < 6; i++) applyStimulus(c[23-4*i -: 4]);
  endtask

  task automatic pulseCtrl(input logic r, input logic rl, input logic p);
    retry  = r;
    relock = rl;
    prog   = p;
    @(posedge clk);
    #1;
    retry  = 1'b0;
    relock = 1'b0;
    prog   = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL timeout: got 0, expected 1");
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin
    rst_n = 1'b0; digit_in = '0; digit_vld = 1'b0;
    retry = 1'b0; relock = 1'b0; prog = 1'b0;
    #23;
    checkOutput("rstState", 32'(state), 0);
    checkOutput("rstPos", 32'(pos), 0);
    checkOutput("rstFail", 32'(fail_cnt), 0);
    checkOutput("rstFlags", {28'd0, open, closed, locked_out, bad_digit | code_done}, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Correct code opens
    for (int i = 0; i < 5; i++) applyStimulus(CODE_A[23-4*i -: 4]);
    checkOutput("posAfter5", 32'(pos), 5);
    applyStimulus(CODE_A[3:0]);
    checkOutput("openState", 32'(state), 1);
    checkOutput("openFlag", 32'(open), 1);
    checkOutput("openFail", 32'(fail_cnt), 0);
    checkOutput("openPos", 32'(pos), 0);
    pulseCtrl(1'b0, 1'b1, 1'b0);
    checkOutput("relockState", 32'(state), 0);

    // Wrong code closes; digits ignored; retry with coincident digit drops digit
    enterCode(WRONG1);
    checkOutput("closedState", 32'(state), 2);
    checkOutput("closedFlag", 32'(closed), 1);
    checkOutput("closedFail", 32'(fail_cnt), 1);
    applyStimulus(4'd5);
    checkOutput("closedIgnPos", 32'(pos), 0);
    checkOutput("closedIgnState", 32'(state), 2);
    digit_in = 4'd7; digit_vld = 1'b1;
    pulseCtrl(1'b1, 1'b0, 1'b0);
    digit_vld = 1'b0;
    checkOutput("retryState", 32'(state), 0);
    checkOutput("retryDropPos", 32'(pos), 0);

    // Two more failures reach lockout
    enterCode(WRONG2);
    checkOutput("fail2", 32'(fail_cnt), 2);
    pulseCtrl(1'b1, 1'b0, 1'b0);
    enterCode(WRONG1);
    checkOutput("lockState", 32'(state), 4);
    checkOutput("lockFlag", 32'(locked_out), 1);
    checkOutput("lockFail", 32'(fail_cnt), 3);
    for (int i = 1; i < 16; i++) begin
      retry     = (i < 4);
      digit_vld = (i == 5);
      digit_in  = 4'd7;
      @(posedge clk); #1;
      checkOutput("lockHold", 32'(state), 4);
    end
    retry = 1'b0; digit_vld = 1'b0;
    @(posedge clk); #1;
    checkOutput("lockExitState", 32'(state), 0);
    checkOutput("lockExitFail", 32'(fail_cnt), 0);
    checkOutput("lockExitFlag", 32'(locked_out), 0);

    // Invalid digit rejected mid-entry
    applyStimulus(4'd7);
    applyStimulus(4'd2);
    applyStimulus(4'd10);
    checkOutput("badPulse", 32'(bad_digit), 1);
    checkOutput("badPosHold", 32'(pos), 2);
    applyStimulus(4'd2);
    checkOutput("badPulseEnd", 32'(bad_digit), 0);
    checkOutput("posAfterBad", 32'(pos), 3);
    applyStimulus(4'd2);
    applyStimulus(4'd9);
    applyStimulus(4'd7);
    checkOutput("badThenOpen", 32'(state), 1);

    // relock beats prog in OPEN
    pulseCtrl(1'b0, 1'b1, 1'b1);
    checkOutput("relockPrio", 32'(state), 0);
    enterCode(CODE_A);

    // Program new code
    pulseCtrl(1'b0, 1'b0, 1'b1);
    checkOutput("progState", 32'(state), 3);
    for (int i = 0; i < 5; i++) applyStimulus(CODE_B[23-4*i -: 4]);
    checkOutput("progNoDone", 32'(code_done), 0);
    applyStimulus(CODE_B[3:0]);
    checkOutput("codeDone", 32'(code_done), 1);
    checkOutput("progExit", 32'(state), 0);
    @(posedge clk); #1;
    checkOutput("codeDoneEnd", 32'(code_done), 0);
    enterCode(CODE_A);
    checkOutput("oldCodeClosed", 32'(state), 2);
    pulseCtrl(1'b1, 1'b0, 1'b0);
    enterCode(CODE_B);
    checkOutput("newCodeOpen", 32'(state), 1);
    checkOutput("newCodeFail", 32'(fail_cnt), 0);

    // Abort programming with a coincident digit: code stays 123456
    pulseCtrl(1'b0, 1'b0, 1'b1);
    applyStimulus(4'd9);
    applyStimulus(4'd9);
    digit_in = 4'd9; digit_vld = 1'b1;
    pulseCtrl(1'b0, 1'b1, 1'b0);
    digit_vld = 1'b0;
    checkOutput("abortState", 32'(state), 0);
    checkOutput("abortPos", 32'(pos), 0);
    enterCode(CODE_B);
    checkOutput("abortKeepsCode", 32'(state), 1);

    // Async reset mid-entry restores the power-on code
    pulseCtrl(1'b0, 1'b1, 1'b0);
    applyStimulus(4'd1);
    applyStimulus(4'd2);
    applyStimulus(4'd3);
    checkOutput("prePosRst", 32'(pos), 3);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("asyncRstPos", 32'(pos), 0);
    checkOutput("asyncRstState", 32'(state), 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    enterCode(CODE_A);
    checkOutput("rstCodeOpen", 32'(state), 1);
    checkOutput("rstCodeFlag", 32'(open), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

endmodule
